// File: rtl/triple_buffer_ctrl_if.sv
// triple_buffer_ctrl_if: frame-done/vsync inputs and room/address status outputs of the triple-buffer controller
interface triple_buffer_ctrl_if;
  logic        i_wr_frame_done;
  logic        i_rd_vsync;
  logic [31:0] o_wr_base_addr;
  logic [31:0] o_rd_base_addr;
  logic [1:0]  o_wr_idx;
  logic [1:0]  o_rd_idx;
  logic [1:0]  o_pend_idx;
  logic        o_new_frame;
  logic        o_frame_valid;
  logic [15:0] o_drop_cnt;
  logic [15:0] o_repeat_cnt;
  modport master (
    output i_wr_frame_done, i_rd_vsync,
    input  o_wr_base_addr, o_rd_base_addr, o_wr_idx, o_rd_idx, o_pend_idx,
    input  o_new_frame, o_frame_valid, o_drop_cnt, o_repeat_cnt
  );
  modport slave (
    input  i_wr_frame_done, i_rd_vsync,
    output o_wr_base_addr, o_rd_base_addr, o_wr_idx, o_rd_idx, o_pend_idx,
    output o_new_frame, o_frame_valid, o_drop_cnt, o_repeat_cnt
  );
endinterface

// File: rtl/triple_buffer_ctrl.sv
// triple_buffer_ctrl: rotates three DDR frame rooms between writer, reader and latest-completed slots
module triple_buffer_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter logic [31:0] ROOM_STRIDE = 32'h0010_0000
) (
  input logic clk_100Mhz,
  input logic sys_rst_n,
  triple_buffer_ctrl_if.slave bus
);
  logic        s1, s2, hist, fresh, fv, nf;
  logic [1:0]  w, r, l;
  logic [31:0] wa, ra;
  logic [15:0] drop, rep;
  logic        de, vs, bad, fresh_n, nf_n, drop_inc, rep_inc;
  logic [1:0]  third, w_n, r_n, l_n;
  assign de       = s2 & ~hist;
  assign vs       = bus.i_rd_vsync;
  assign bad      = (&w) | (&r) | (&l);
  assign third    = 2'd3 - r - w;
  assign w_n      = bad ? 2'd0 : de ? third : w;
  assign r_n      = bad ? 2'd2 : (de && vs) ? w : (vs && fresh) ? l : r;
  assign l_n      = bad ? 2'd2 : de ? w : l;
  assign fresh_n  = bad ? 1'b0 : de ? ~vs : vs ? 1'b0 : fresh;
  assign nf_n     = ~bad & vs & (de | fresh);
  assign drop_inc = ~bad & de & fresh & (drop != 16'hFFFF);
  assign rep_inc  = ~bad & vs & ~de & ~fresh & fv & (rep != 16'hFFFF);
  // addresses are computed from the next index so they move on the same edge as the index
  always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      hist  <= 1'b0;
      w     <= 2'd0;
      r     <= 2'd2;
      l     <= 2'd2;
      fresh <= 1'b0;
      fv    <= 1'b0;
      nf    <= 1'b0;
      wa    <= BASE_ADDR;
      ra    <= BASE_ADDR + 32'd2 * ROOM_STRIDE;
      drop  <= 16'd0;
      rep   <= 16'd0;
    end else begin
      s1    <= bus.i_wr_frame_done;
      s2    <= s1;
      hist  <= s2;
      w     <= w_n;
      r     <= r_n;
      l     <= l_n;
      fresh <= fresh_n;
      fv    <= fv | (de & ~bad);
      nf    <= nf_n;
      wa    <= BASE_ADDR + 32'(w_n) * ROOM_STRIDE;
      ra    <= BASE_ADDR + 32'(r_n) * ROOM_STRIDE;
      drop  <= drop + 16'(drop_inc);
      rep   <= rep + 16'(rep_inc);
    end
  end
  assign bus.o_wr_idx       = w;
  assign bus.o_rd_idx       = r;
  assign bus.o_pend_idx     = l;
  assign bus.o_wr_base_addr = wa;
  assign bus.o_rd_base_addr = ra;
  assign bus.o_new_frame    = nf;
  assign bus.o_frame_valid  = fv;
  assign bus.o_drop_cnt     = drop;
  assign bus.o_repeat_cnt   = rep;
endmodule

// File: doc/triple_buffer_ctrl.md
TRIPLE_BUFFER_CTRL -- requirements
Module: triple_buffer_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0100_0000, DDR byte address of room 0.
REQ-002 SHALL have parameter ROOM_STRIDE, default 32'h0010_0000, byte distance between consecutive rooms.
REQ-003 SHALL have port clk_100Mhz  in  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port sys_rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_wr_frame_done  in  1  asynchronous level from the capture domain; each rising edge marks one frame fully written.
REQ-006 SHALL have port i_rd_vsync  in  1  synchronous single-cycle pulse marking the reader's frame start.
REQ-007 SHALL have port o_wr_base_addr  out  32  frame base address for the AXI writer.
REQ-008 SHALL have port o_rd_base_addr  out  32  frame base address for the AXI reader.
REQ-009 SHALL have ports o_wr_idx, o_rd_idx, o_pend_idx  out  2 each  room indices: writer, reader, latest completed.
REQ-010 SHALL have port o_new_frame  out  1  one-cycle pulse when the reader switches to a fresh frame.
REQ-011 SHALL have port o_frame_valid  out  1  sticky; at least one frame completed since reset.
REQ-012 SHALL have ports o_drop_cnt, o_repeat_cnt  out  16 each  saturating counts of overwritten-unread frames and stale reader frames.

Function
REQ-013 SHALL synchronise i_wr_frame_done through two flops plus one history flop; done_edge = sync2 AND NOT history.
REQ-014 done_edge SHALL take effect on the second rising edge after the edge that first samples i_wr_frame_done high; a held-high level SHALL yield exactly one event.
REQ-015 i_rd_vsync SHALL take effect on the same rising edge that samples it.
REQ-016 Internal state: W, R, L (2 bits each) and flag fresh; o_wr_idx=W, o_rd_idx=R, o_pend_idx=L.
REQ-017 Invariant: W never equals R; index 3 is unreachable and, if it occurs, SHALL force W=0, R=2, L=2, fresh=0 on the next edge.
REQ-018 done_edge only: L<=W; W<=3-R-W (the third room); fresh<=1; frame_valid<=1; if fresh was 1, drop_cnt increments.
REQ-019 vsync only, fresh=1: R<=L; fresh<=0; o_new_frame=1 for one cycle.
REQ-020 vsync only, fresh=0: R unchanged; repeat_cnt increments only when frame_valid=1.
REQ-021 done_edge and vsync on the same edge: R<=W_old; L<=W_old; W<=3-R_old-W_old; fresh<=0; frame_valid<=1; o_new_frame pulses; drop_cnt increments if fresh was 1.
REQ-022 Addresses SHALL be registered: o_x_base_addr = BASE_ADDR + idx*ROOM_STRIDE, updated on the same edge as the index (no extra cycle).
REQ-023 Counters SHALL saturate at 16'hFFFF without wrapping.
REQ-024 o_new_frame SHALL be 0 in every cycle not described in REQ-019/REQ-021.

Reset
REQ-025 While sys_rst_n=0, asynchronously: W=0, R=2, L=2, fresh=0, synchroniser flops=0, o_wr_base_addr=32'h0100_0000, o_rd_base_addr=32'h0120_0000, o_new_frame=0, o_frame_valid=0, both counters=0.
REQ-026 Reset asserted mid-operation SHALL abandon all pending events; after release, an i_wr_frame_done already high SHALL produce one done_edge.

Verification
REQ-027 Reset, then no stimulus -> wr addr 0x0100_0000, rd addr 0x0120_0000, idx W/R/L=0/2/2, all flags and counters 0.
REQ-028 One done rise, then vsync -> after done: W=1 (0x0110_0000), L=0, frame_valid=1; at vsync: R=0 (rd 0x0100_0000), o_new_frame high exactly one cycle.
REQ-029 From reset, two done rises without vsync -> W 0->1->0, L=1, drop_cnt=1, R stays 2.
REQ-030 After REQ-028, vsync with no new done -> repeat_cnt=1, R=0 unchanged, o_new_frame stays 0.
REQ-031 From W=1, R=0, fresh=0, done_edge coincident with vsync -> R=1, L=1, W=2, o_new_frame pulse, drop_cnt unchanged.
REQ-032 i_wr_frame_done held high 1000 cycles, sys_rst_n pulsed low mid-hold -> exactly one done_edge before and one after reset; W never equals R in any cycle.
